// File: rtl/perif_timer.sv
// Memory-mapped 4-register down-counter timer with prescaler, one-shot/auto-reload and sticky IRQ.
// Latency: zero-wait combinational read; writes take effect at the rising edge they are presented on.
// Backpressure: none; every qualified access completes in the cycle it is presented.
// Ports: i_clk/i_rst (async active-low), i_cs_perif/i_addr_bus/i_wr/i_rd bus strobes,
//        io_data_bus shared tri-state data (write in, read out), o_irq level interrupt.
module perif_timer #(
  parameter int          DATA_WIDTH = 16,
  parameter int          ADDR_WIDTH = 10,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cs_perif,
  input  logic [ADDR_WIDTH-1:0] i_addr_bus,
  input  logic                  i_wr,
  input  logic                  i_rd,
  inout  wire  [DATA_WIDTH-1:0] io_data_bus,
  output logic                  o_irq
);

  localparam logic [ADDR_WIDTH-3:0] BASE_HI = BASE_ADDR[ADDR_WIDTH-1:2];
  localparam logic [DATA_WIDTH-1:0] ONE     = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state_q, state_d;
  logic                  auto_q, auto_d;
  logic                  irq_en_q, irq_en_d;
  logic [7:0]            presc_q, presc_d;
  logic [DATA_WIDTH-1:0] load_q, load_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic                  exp_q, exp_d;
  logic [7:0]            psc_q, psc_d;

  logic                  hit, wr_vld, rd_vld;
  logic                  wr_ctrl, wr_load, wr_status;
  logic                  run, tick, expire, stop_req;
  logic [DATA_WIDTH-1:0] wdat, rdata;

  // ---------------- bus decode ----------------
  assign hit       = i_cs_perif && (i_addr_bus[ADDR_WIDTH-1:2] == BASE_HI);
  assign wr_vld    = hit && i_wr && !i_rd;
  // Gated by reset so the bus is released while the block is held in reset.
  assign rd_vld    = hit && i_rd && !i_wr && i_rst;
  assign wdat      = io_data_bus;
  assign wr_ctrl   = wr_vld && (i_addr_bus[1:0] == 2'd0);
  assign wr_load   = wr_vld && (i_addr_bus[1:0] == 2'd1);
  assign wr_status = wr_vld && (i_addr_bus[1:0] == 2'd3);

  // ---------------- timer core ----------------
  assign run      = (state_q == RUN);
  assign tick     = run && (psc_q == presc_q);
  assign expire   = tick && (count_q == '0);
  assign stop_req = wr_ctrl && !wdat[0];

  always_comb begin
    state_d  = state_q;
    auto_d   = auto_q;
    irq_en_d = irq_en_q;
    presc_d  = presc_q;
    load_d   = load_q;
    count_d  = count_q;
    exp_d    = exp_q;
    psc_d    = psc_q;

    case (state_q)
      IDLE: begin
        // Start latches the LOAD value held before this edge.
        if (wr_ctrl && wdat[0]) begin
          state_d = RUN;
          count_d = load_q;
        end
      end
      RUN: begin
        psc_d = tick ? 8'd0 : psc_q + 8'd1;
        if (expire) begin
          if (auto_q) begin
            count_d = load_q;
          end else begin
            state_d = IDLE;
          end
        end else if (tick && !stop_req) begin
          count_d = count_q - ONE;
        end
        // A stop holds COUNT; an expiry in the same cycle still applies its own rule above.
        if (stop_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      psc_d = 8'd0;
    end

    // Set has priority over a same-cycle write-1 clear.
    if (wr_status && wdat[0]) begin
      exp_d = 1'b0;
    end
    if (expire) begin
      exp_d = 1'b1;
    end

    if (wr_ctrl) begin
      auto_d   = wdat[1];
      irq_en_d = wdat[2];
      presc_d  = wdat[15:8];
    end
    if (wr_load) begin
      load_d = wdat;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= IDLE;
      auto_q   <= 1'b0;
      irq_en_q <= 1'b0;
      presc_q  <= 8'd0;
      load_q   <= '0;
      count_q  <= '0;
      exp_q    <= 1'b0;
      psc_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      auto_q   <= auto_d;
      irq_en_q <= irq_en_d;
      presc_q  <= presc_d;
      load_q   <= load_d;
      count_q  <= count_d;
      exp_q    <= exp_d;
      psc_q    <= psc_d;
    end
  end

  // ---------------- read path ----------------
  // CTRL.EN is the run state itself, so a one-shot expiry clears it automatically.
  always_comb begin
    rdata = '0;
    case (i_addr_bus[1:0])
      2'd0: begin
        rdata[15:8] = presc_q;
        rdata[2:0]  = {irq_en_q, auto_q, run};
      end
      2'd1:    rdata = load_q;
      2'd2:    rdata = count_q;
      default: rdata[0] = exp_q;
    endcase
  end

  assign io_data_bus = rd_vld ? rdata : {DATA_WIDTH{1'bz}};
  assign o_irq       = exp_q && irq_en_q;

endmodule

// File: tb/tb_perif_timer.sv
module tb_perif_timer;
  localparam int DW = 16;
  localparam int AW = 10;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          cs = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          tb_drv = 1'b0;
  logic [DW-1:0] tb_dat = '0;
  logic          irq;
  wire  [DW-1:0] bus;
  logic [DW-1:0] zz = {DW{1'bz}};
  logic [DW-1:0] rd_val;

  assign bus = tb_drv ? tb_dat : {DW{1'bz}};

  perif_timer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cs_perif(cs), .i_addr_bus(addr),
    .i_wr(wr), .i_rd(rd), .io_data_bus(bus), .o_irq(irq)
  );

  always #10 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  // While running, COUNT is derived from edges elapsed since the last start/reload:
  // count = L - j/(P+1), expiry on the edge where j reaches (L+1)*(P+1).
  bit m_run, m_auto, m_irqen, m_exp;
  int m_presc, m_load, m_L, m_j, m_hold;

  task automatic m_reset();
    m_run = 0; m_auto = 0; m_irqen = 0; m_exp = 0;
    m_presc = 0; m_load = 0; m_L = 0; m_j = 0; m_hold = 0;
  endtask

  function automatic int m_count();
    return m_run ? (m_L - m_j / (m_presc + 1)) : m_hold;
  endfunction

  function automatic logic [DW-1:0] m_reg(input int k);
    int v;
    case (k)
      0:       v = m_presc * 256 + int'(m_irqen) * 4 + int'(m_auto) * 2 + int'(m_run);
      1:       v = m_load;
      2:       v = m_count();
      default: v = int'(m_exp);
    endcase
    return v[DW-1:0];
  endfunction

  task automatic m_edge(input bit wc, input bit wl, input bit ws, input int d);
    int pre;
    bit expire;
    pre    = m_count();
    expire = m_run && ((m_j + 1) == (m_L + 1) * (m_presc + 1));
    if (m_run) begin
      if (expire) begin
        m_exp = 1;
        if (m_auto) begin
          m_L = m_load; m_j = 0; m_hold = m_load;
        end else begin
          m_run = 0; m_hold = 0;
        end
      end else begin
        m_j++;
      end
      if (m_run && wc && d[0] == 1'b0) begin
        m_run  = 0;
        m_hold = expire ? m_load : pre;
      end
    end else if (wc && d[0]) begin
      m_run = 1; m_L = m_load; m_j = 0;
    end
    if (ws && d[0] && !expire) m_exp = 0;
    if (wc) begin
      m_auto = d[1]; m_irqen = d[2]; m_presc = (d >> 8) & 255;
    end
    if (wl) m_load = d & 16'hFFFF;
  endtask

  // One bus cycle: drive after negedge, check pre-edge values, step model on the edge.
  task automatic cyc(input bit c, input int a, input bit w, input bit r, input int d);
    bit hit;
    int off;
    cs = c; addr = a[AW-1:0]; wr = w; rd = r; tb_drv = w; tb_dat = d[DW-1:0];
    #1;
    hit = c && (a / 4 == 0);
    off = a % 4;
    rd_val = bus;
    if (hit && r && !w) check_eq($sformatf("rd_off%0d", off), bus, m_reg(off));
    else if (!w)        check_eq("bus_z", bus, zz);
    check_eq("irq", {{(DW-1){1'b0}}, irq}, {{(DW-1){1'b0}}, (m_exp & m_irqen)});
    @(posedge i_clk);
    if (hit && w && !r) m_edge(off == 0, off == 1, off == 3, d);
    else                m_edge(0, 0, 0, 0);
    @(negedge i_clk);
    cs = 0; wr = 0; rd = 0; tb_drv = 0;
  endtask

  task automatic wr_reg(input int off, input int d); cyc(1, off, 1, 0, d); endtask
  task automatic rd_reg(input int off);              cyc(1, off, 0, 1, 0); endtask

  int exp5 [5] = '{2, 1, 0, 9, 8};

  initial begin
    m_reset();
    // Reset asserted: bus must float even with a read strobe present.
    @(negedge i_clk);
    cs = 1; rd = 1; addr = '0;
    #1;
    check_eq("rst_bus_z", bus, zz);
    check_eq("rst_irq", {{(DW-1){1'b0}}, irq}, '0);
    cs = 0; rd = 0;
    @(negedge i_clk);
    i_rst = 1;
    @(negedge i_clk);

    // 1: reset values
    for (int k = 0; k < 4; k++) begin
      rd_reg(k);
      check_eq("t1_reset_val", rd_val, 16'h0000);
    end
    cyc(0, 0, 0, 0, 0);

    // 2: one-shot, LOAD=4, PRESC=0, IRQ_EN
    wr_reg(1, 4);
    wr_reg(0, 16'h0005);
    for (int k = 0; k < 5; k++) rd_reg(3);
    check_eq("t2_exp_before", rd_val, 16'h0000);
    rd_reg(3);
    check_eq("t2_exp_set", rd_val, 16'h0001);
    check_eq("t2_irq_set", {{(DW-1){1'b0}}, irq}, 16'h0001);
    rd_reg(0);
    check_eq("t2_ctrl", rd_val, 16'h0004);
    rd_reg(2);
    check_eq("t2_count", rd_val, 16'h0000);
    wr_reg(3, 1);
    check_eq("t2_irq_clr", {{(DW-1){1'b0}}, irq}, 16'h0000);

    // 3: auto-reload, LOAD=2, PRESC=3
    wr_reg(1, 2);
    wr_reg(0, 16'h0303);
    for (int k = 0; k < 24; k++) begin
      rd_reg(2);
      check_eq($sformatf("t3_count_%0d", k), rd_val, 16'(2 - ((k / 4) % 3)));
    end
    rd_reg(0);
    check_eq("t3_ctrl_run", rd_val, 16'h0303);

    // 4: STATUS clear on the same edge as the third expiry (edge 36)
    for (int k = 26; k < 36; k++) begin
      if (k == 30) wr_reg(3, 1);
      else         rd_reg(3);
    end
    wr_reg(3, 1);
    rd_reg(3);
    check_eq("t4_set_wins", rd_val, 16'h0001);

    // 5: mid-run LOAD change applies at the next reload
    wr_reg(0, 0);
    wr_reg(3, 1);
    wr_reg(1, 3);
    wr_reg(0, 16'h0003);
    wr_reg(1, 9);
    for (int k = 0; k < 5; k++) begin
      rd_reg(2);
      check_eq($sformatf("t5_count_%0d", k), rd_val, 16'(exp5[k]));
    end
    wr_reg(0, 0);

    // 6: bus negatives
    wr_reg(1, 16'h1234);
    for (int k = 0; k < 4; k++) cyc(0, k, 1, 0, 16'hFFFF);
    for (int k = 0; k < 4; k++) cyc(0, k, 0, 1, 0);
    cyc(1, 1, 1, 1, 16'h5555);
    cyc(1, 4, 1, 0, 16'hAAAA);
    cyc(1, 5, 0, 1, 0);
    rd_reg(1);
    check_eq("t6_load_kept", rd_val, 16'h1234);

    // Reset during RUN with IRQ pending
    wr_reg(1, 1);
    wr_reg(0, 16'h0007);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0);
    check_eq("t6_irq_pre_rst", {{(DW-1){1'b0}}, irq}, 16'h0001);
    cs = 1; rd = 1; addr = 10'd2;
    i_rst = 0;
    #1;
    check_eq("t6_rst_irq", {{(DW-1){1'b0}}, irq}, 16'h0000);
    check_eq("t6_rst_bus_z", bus, zz);
    m_reset();
    #1;
    i_rst = 1;
    cs = 0; rd = 0;
    for (int k = 0; k < 4; k++) begin
      rd_reg(k);
      check_eq("t6_after_rst", rd_val, 16'h0000);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int r, d;
      r = $urandom_range(0, 99);
      if (r < 35) begin
        rd_reg($urandom_range(0, 3));
      end else if (r < 45) begin
        wr_reg(1, $urandom_range(0, 6));
      end else if (r < 55) begin
        wr_reg(3, $urandom_range(0, 1));
      end else if (r < 70) begin
        if (m_run) begin
          if ($urandom_range(0, 1) == 0)
            d = $urandom_range(0, 3) * 256 + $urandom_range(0, 3) * 2;
          else
            d = m_presc * 256 + $urandom_range(0, 3) * 2 + 1;
        end else begin
          d = $urandom_range(0, 3) * 256 + $urandom_range(0, 7);
        end
        wr_reg(0, d);
      end else if (r < 80) begin
        cyc(0, 0, 0, 0, 0);
      end else if (r < 85) begin
        d = $urandom_range(0, 1);
        cyc(0, $urandom_range(0, 3), d[0], !d[0], $urandom_range(0, 65535));
      end else if (r < 90) begin
        cyc(1, $urandom_range(0, 3), 1, 1, $urandom_range(0, 65535));
      end else begin
        d = $urandom_range(0, 1);
        cyc(1, $urandom_range(4, 1023), d[0], !d[0], $urandom_range(0, 65535));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
